// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                              |
// | Desc     : Shares one single-ported variable-latency memory between      |
// |            instruction fetch and the MEM stage; freezes the pipeline     |
// |            while a data access is outstanding. Optional watchdog under   |
// |            macro MEM_TIMEOUT_EN.                                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] val_rm,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              freeze,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_D_ACC  = 3'd1,
    ST_I_ACC  = 3'd2,
    ST_D_RESP = 3'd3,
    ST_I_RESP = 3'd4
  } state_t;

  localparam logic              c_grant_inst   = 1'b0;
  localparam logic              c_grant_data   = 1'b1;
  localparam logic [7:0]        c_timeout_last = 8'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] c_abort_data   = DATA_W'(32'hDEADBEEF);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_grant;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic [DATA_W-1:0] r_if_rdata;

  logic              w_data_req;
  logic              w_in_idle;
  logic              w_in_acc;
  logic              w_grant_d;
  logic              w_grant_i;
  logic              w_abort;
  logic              w_acc_done;
  logic [DATA_W-1:0] w_rd_val;

  assign w_data_req = mem_r_en | mem_w_en;
  assign w_in_idle  = (r_state == ST_IDLE);
  assign w_in_acc   = (r_state == ST_D_ACC) || (r_state == ST_I_ACC);

  // Data wins unless fetch is also waiting and data was served last.
  assign w_grant_d  = w_in_idle && w_data_req && (!if_req || (r_last_grant == c_grant_inst));
  assign w_grant_i  = w_in_idle && !w_grant_d && if_req;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic       r_mem_err;

  assign w_abort = w_in_acc && !mem_ready && (r_wait_cnt == c_timeout_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= 8'd0;
      r_mem_err  <= 1'b0;
    end else begin
      if (w_grant_d || w_grant_i) begin
        r_wait_cnt <= 8'd0;
      end else if (w_in_acc && !mem_ready) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
      if (w_abort) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  assign mem_err = r_mem_err;
`else
  logic w_unused_timeout;

  assign w_abort          = 1'b0;
  assign w_unused_timeout = ^c_timeout_last;
  assign mem_err          = 1'b0;
`endif

  assign w_acc_done = w_in_acc && (mem_ready || w_abort);
  assign w_rd_val   = w_abort ? c_abort_data : mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = ST_D_ACC;
        end else if (w_grant_i) begin
          w_state_nxt = ST_I_ACC;
        end
      end
      ST_D_ACC: begin
        if (w_acc_done) begin
          w_state_nxt = ST_D_RESP;
        end
      end
      ST_I_ACC: begin
        if (w_acc_done) begin
          w_state_nxt = ST_I_RESP;
        end
      end
      ST_D_RESP: w_state_nxt = ST_IDLE;
      ST_I_RESP: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Request side is latched at grant and held untouched until completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_dm_rdata   <= '0;
      r_if_rdata   <= '0;
      r_last_grant <= c_grant_inst;
    end else if (w_grant_d) begin
      r_mem_req    <= 1'b1;
      r_mem_we     <= mem_w_en;
      r_mem_addr   <= alu_result;
      r_mem_wdata  <= val_rm;
    end else if (w_grant_i) begin
      r_mem_req    <= 1'b1;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= if_addr;
      r_mem_wdata  <= '0;
    end else if (w_acc_done) begin
      r_mem_req <= 1'b0;
      if (r_state == ST_D_ACC) begin
        r_last_grant <= c_grant_data;
        if (!r_mem_we) begin
          r_dm_rdata <= w_rd_val;
        end
      end else begin
        r_last_grant <= c_grant_inst;
        r_if_rdata   <= w_rd_val;
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_rdata  = r_if_rdata;
  assign dm_done   = (r_state == ST_D_RESP);
  assign if_valid  = (r_state == ST_I_RESP);
  // The pipeline advances only in the cycle the data response is presented.
  assign freeze    = w_data_req && (r_state != ST_D_RESP);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_port_arbiter                                           |
// | Desc     : Self-checking bench for mem_port_arbiter (default build).     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] val_rm = '0;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        freeze;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_err;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .alu_result(alu_result), .val_rm(val_rm),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .freeze(freeze),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory: answers after mem_lat cycles of mem_req without ready.
  logic [31:0] mem_arr [256];
  int          mem_lat = 0;
  int          mem_cnt;
  assign mem_ready = mem_req && (mem_cnt >= mem_lat);
  assign mem_rdata = mem_arr[mem_addr[9:2]];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_cnt <= 0;
    end else if (mem_req && mem_ready) begin
      mem_cnt <= 0;
      if (mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
    end else if (mem_req) begin
      mem_cnt <= mem_cnt + 1;
    end
  end

  // Transaction-level model: who owns the memory, who is being answered.
  int          m_owner;   // 0 none, 1 data, 2 fetch
  int          m_resp;    // 0 none, 1 data, 2 fetch
  bit          m_last_data;
  bit          m_we;
  logic [31:0] m_addr, m_wdata, m_dm, m_if;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner = 0; m_resp = 0; m_last_data = 0; m_we = 0;
      m_addr = 0; m_wdata = 0; m_dm = 0; m_if = 0;
    end else if (m_resp != 0) begin
      m_resp = 0;
    end else if (m_owner != 0) begin
      if (mem_ready) begin
        if (m_owner == 1 && !m_we) m_dm = mem_rdata;
        if (m_owner == 2) m_if = mem_rdata;
        m_last_data = (m_owner == 1);
        m_resp  = m_owner;
        m_owner = 0;
      end
    end else if ((mem_r_en || mem_w_en) && (!if_req || !m_last_data)) begin
      m_owner = 1; m_we = mem_w_en; m_addr = alu_result; m_wdata = val_rm;
    end else if (if_req) begin
      m_owner = 2; m_we = 0; m_addr = if_addr;
    end
  end

  always @(negedge clk) begin
    chk("mem_req",  32'(mem_req),  32'(m_owner != 0));
    chk("mem_we",   32'(mem_we),   32'(m_we));
    chk("mem_addr", mem_addr,      m_addr);
    if (m_owner == 1 && m_we) chk("mem_wdata", mem_wdata, m_wdata);
    chk("dm_done",  32'(dm_done),  32'(m_resp == 1));
    chk("if_valid", 32'(if_valid), 32'(m_resp == 2));
    chk("freeze",   32'(freeze),   32'((mem_r_en || mem_w_en) && m_resp != 1));
    chk("dm_rdata", dm_rdata,      m_dm);
    chk("if_rdata", if_rdata,      m_if);
    chk("mem_err",  32'(mem_err),  32'd0);
  end

  // One data access: counts freeze cycles and done pulses, captures the request.
  task automatic run_data(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input int lat, output int frz, output int dn,
                          output logic cwe, output logic [31:0] caddr, output logic [31:0] cwd);
    bit got = 0;
    bit seen = 0;
    frz = 0; dn = 0; cwe = 0; caddr = 0; cwd = 0;
    mem_lat = lat; mem_r_en = r; mem_w_en = w; alu_result = a; val_rm = d;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (freeze) frz++;
      if (mem_req && !seen) begin
        seen = 1; cwe = mem_we; caddr = mem_addr; cwd = mem_wdata;
      end
      if (dm_done) begin dn++; got = 1; end
    end
    if (!got) chk("dm_done_wait", 32'd0, 32'd1);
    @(posedge clk); #1;
    mem_r_en = 0; mem_w_en = 0;
    repeat (3) begin
      @(negedge clk);
      if (dm_done) dn++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int          frz, dn;
    logic        cwe;
    logic [31:0] caddr, cwd;
    logic [11:0] d_pat, i_pat;
    logic [31:0] a_c1, a_c4;
    bit          got;

    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    mem_arr[8'h40] = 32'hCAFE0001;   // 0x100
    mem_arr[8'h80] = 32'h00001013;   // 0x200
    mem_arr[8'h20] = 32'h0BAD0080;   // 0x080

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_dm_rdata", dm_rdata, 32'd0);
    @(posedge clk); #1;

    // Load with three wait cycles
    run_data(1, 0, 32'h100, 32'h0, 3, frz, dn, cwe, caddr, cwd);
    chk("t1_freeze_cycles", 32'(frz), 32'd5);
    chk("t1_done_pulses", 32'(dn), 32'd1);
    chk("t1_mem_we", 32'(cwe), 32'd0);
    chk("t1_dm_rdata", dm_rdata, 32'hCAFE0001);

    // Store
    run_data(0, 1, 32'h40, 32'h12345678, 1, frz, dn, cwe, caddr, cwd);
    chk("t2_mem_we", 32'(cwe), 32'd1);
    chk("t2_mem_addr", caddr, 32'h40);
    chk("t2_mem_wdata", cwd, 32'h12345678);
    chk("t2_dm_rdata_kept", dm_rdata, 32'hCAFE0001);

    // Fetch with if_req dropped mid-access
    mem_lat = 2; if_addr = 32'h200; if_req = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = mem_req; end
    @(posedge clk); #1 if_req = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = if_valid; end
    chk("if_drop_valid", 32'(got), 32'd1);
    chk("if_drop_rdata", if_rdata, 32'h00001013);
    repeat (2) @(posedge clk); #1;

    // Contention with ready tied high
    mem_lat = 0; alu_result = 32'h80; if_addr = 32'h200; mem_r_en = 1; if_req = 1;
    d_pat = '0; i_pat = '0; a_c1 = '0; a_c4 = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      d_pat[c] = dm_done;
      i_pat[c] = if_valid;
      if (c == 1) a_c1 = mem_addr;
      if (c == 4) a_c4 = mem_addr;
    end
    @(posedge clk); #1 mem_r_en = 0; if_req = 0;
    chk("t3_dm_done_pattern", 32'(d_pat), 32'h104);
    chk("t3_if_valid_pattern", 32'(i_pat), 32'h820);
    chk("t3_first_grant_data", a_c1, 32'h80);
    chk("t3_second_grant_inst", a_c4, 32'h200);
    repeat (2) @(posedge clk); #1;

    // Read and write both set
    run_data(1, 1, 32'h44, 32'hA5A55A5A, 0, frz, dn, cwe, caddr, cwd);
    chk("t4_mem_we", 32'(cwe), 32'd1);
    chk("t4_done_pulses", 32'(dn), 32'd1);
    chk("t4_dm_rdata_kept", dm_rdata, 32'h0BAD0080);

    // Reset in the second cycle of a data access
    mem_lat = 20; alu_result = 32'h100; mem_r_en = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = mem_req; end
    @(negedge clk);
    #2 rst = 0;
    #1;
    chk("t5_mem_req_async", 32'(mem_req), 32'd0);
    chk("t5_dm_done", 32'(dm_done), 32'd0);
    chk("t5_mem_addr", mem_addr, 32'd0);
    chk("t5_dm_rdata", dm_rdata, 32'd0);
    mem_r_en = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    run_data(1, 0, 32'h40, 32'h0, 0, frz, dn, cwe, caddr, cwd);
    chk("t5_fresh_done", 32'(dn), 32'd1);
    chk("t5_fresh_rdata", dm_rdata, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
